// File: rtl/mano_io_pkg.sv
// Shared types and constants for the MANO serial I/O unit.
package mano_io_pkg;
    localparam int DATA_BITS       = 8;
    localparam int CLK_DIV_DEFAULT = 434;

    typedef enum logic [1:0] {
        RX_IDLE, RX_START, RX_DATA, RX_STOP
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE, TX_START, TX_DATA, TX_STOP
    } tx_state_t;
endpackage

// File: rtl/mano_io_if.sv
// Control-unit side bus of the MANO I/O unit.
interface mano_io_if;
    logic [7:0] ac_in;
    logic       inp_exec;
    logic       out_exec;
    logic       ion;
    logic       iof;
    logic       int_ack;
    logic [7:0] inpr_out;
    logic       fgi;
    logic       fgo;
    logic       ien;
    logic       int_req;
    logic       rx_overrun;

    modport master (
        output ac_in, inp_exec, out_exec, ion, iof, int_ack,
        input  inpr_out, fgi, fgo, ien, int_req, rx_overrun
    );

    modport slave (
        input  ac_in, inp_exec, out_exec, ion, iof, int_ack,
        output inpr_out, fgi, fgo, ien, int_req, rx_overrun
    );
endinterface

// File: rtl/mano_uart_rx.sv
// UART receiver: rx synchroniser, frame FSM, byte_valid / framing_err pulses.
module mano_uart_rx
    import mano_io_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       framing_err
);
    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] HALF = CW'(CLK_DIV / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(CLK_DIV - 1);

    rx_state_t     st_q, st_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    sh_q, sh_d;
    logic          s1_q, rx_s;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q  <= 1'b1;
            rx_s  <= 1'b1;
            st_q  <= RX_IDLE;
            cnt_q <= '0;
            idx_q <= '0;
            sh_q  <= '0;
        end else begin
            s1_q  <= rx;
            rx_s  <= s1_q;
            st_q  <= st_d;
            cnt_q <= cnt_d;
            idx_q <= idx_d;
            sh_q  <= sh_d;
        end
    end

    always_comb begin
        st_d        = st_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        sh_d        = sh_q;
        byte_valid  = 1'b0;
        framing_err = 1'b0;
        unique case (st_q)
            RX_IDLE: if (!rx_s) begin
                st_d  = RX_START;
                cnt_d = HALF;
            end
            RX_START: if (cnt_q == '0) begin
                // A start bit that is gone by mid-bit was a glitch
                if (!rx_s) begin
                    st_d  = RX_DATA;
                    cnt_d = FULL;
                    idx_d = '0;
                end else begin
                    st_d = RX_IDLE;
                end
            end else begin
                cnt_d = cnt_q - CW'(1);
            end
            RX_DATA: if (cnt_q == '0) begin
                sh_d  = {rx_s, sh_q[7:1]};
                cnt_d = FULL;
                if (idx_q == 3'(DATA_BITS - 1)) st_d = RX_STOP;
                else idx_d = idx_q + 3'd1;
            end else begin
                cnt_d = cnt_q - CW'(1);
            end
            RX_STOP: if (cnt_q == '0) begin
                st_d        = RX_IDLE;
                byte_valid  = rx_s;
                framing_err = !rx_s;
            end else begin
                cnt_d = cnt_q - CW'(1);
            end
            default: st_d = RX_IDLE;
        endcase
    end

    assign rx_byte = sh_q;
endmodule

// File: rtl/mano_io_unit.sv
// MANO I/O unit: INPR/OUTR, FGI/FGO, IEN and the UART transmitter.
module mano_io_unit
    import mano_io_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      rx,
    output logic      tx,
    mano_io_if.slave  bus
);
    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] FULL = CW'(CLK_DIV - 1);

    logic [7:0]    rx_byte, inpr_q;
    logic          byte_valid, framing_unused;
    logic          fgi_q, ien_q, ovr_q;
    tx_state_t     tx_st_q, tx_st_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]    tx_idx_q, tx_idx_d;
    logic [7:0]    outr_q, outr_d;
    logic          fgo_q, fgo_d, tx_q, tx_d;
    logic          fgi_free;

    mano_uart_rx #(.CLK_DIV(CLK_DIV)) u_rx (
        .clk         (clk),
        .reset       (reset),
        .rx          (rx),
        .rx_byte     (rx_byte),
        .byte_valid  (byte_valid),
        .framing_err (framing_unused)
    );

    // An INP in the same cycle frees INPR for the arriving byte
    assign fgi_free = !fgi_q || bus.inp_exec;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inpr_q <= '0;
            fgi_q  <= 1'b0;
            ovr_q  <= 1'b0;
            ien_q  <= 1'b0;
        end else begin
            if (byte_valid && fgi_free) begin
                inpr_q <= rx_byte;
                fgi_q  <= 1'b1;
            end else begin
                if (byte_valid) ovr_q <= 1'b1;
                if (bus.inp_exec) fgi_q <= 1'b0;
            end
            if (bus.int_ack || bus.iof) ien_q <= 1'b0;
            else if (bus.ion) ien_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_st_q  <= TX_IDLE;
            tx_cnt_q <= '0;
            tx_idx_q <= '0;
            outr_q   <= '0;
            fgo_q    <= 1'b1;
            tx_q     <= 1'b1;
        end else begin
            tx_st_q  <= tx_st_d;
            tx_cnt_q <= tx_cnt_d;
            tx_idx_q <= tx_idx_d;
            outr_q   <= outr_d;
            fgo_q    <= fgo_d;
            tx_q     <= tx_d;
        end
    end

    always_comb begin
        tx_st_d  = tx_st_q;
        tx_cnt_d = tx_cnt_q;
        tx_idx_d = tx_idx_q;
        outr_d   = outr_q;
        fgo_d    = fgo_q;
        unique case (tx_st_q)
            TX_IDLE: if (bus.out_exec && fgo_q) begin
                outr_d   = bus.ac_in;
                fgo_d    = 1'b0;
                tx_st_d  = TX_START;
                tx_cnt_d = FULL;
            end
            TX_START: if (tx_cnt_q == '0) begin
                tx_st_d  = TX_DATA;
                tx_cnt_d = FULL;
                tx_idx_d = '0;
            end else begin
                tx_cnt_d = tx_cnt_q - CW'(1);
            end
            TX_DATA: if (tx_cnt_q == '0) begin
                tx_cnt_d = FULL;
                if (tx_idx_q == 3'(DATA_BITS - 1)) tx_st_d = TX_STOP;
                else tx_idx_d = tx_idx_q + 3'd1;
            end else begin
                tx_cnt_d = tx_cnt_q - CW'(1);
            end
            TX_STOP: if (tx_cnt_q == '0) begin
                tx_st_d = TX_IDLE;
                fgo_d   = 1'b1;
            end else begin
                tx_cnt_d = tx_cnt_q - CW'(1);
            end
            default: tx_st_d = TX_IDLE;
        endcase
        // Line level is registered from next state so tx never glitches
        tx_d = 1'b1;
        if (tx_st_d == TX_START) tx_d = 1'b0;
        else if (tx_st_d == TX_DATA) tx_d = outr_d[tx_idx_d];
    end

    assign tx             = tx_q;
    assign bus.inpr_out   = inpr_q;
    assign bus.fgi        = fgi_q;
    assign bus.fgo        = fgo_q;
    assign bus.ien        = ien_q;
    assign bus.rx_overrun = ovr_q;
    assign bus.int_req    = ien_q && (fgi_q || fgo_q);
endmodule

// File: tb/tb_mano_io_unit.sv
// Directed bench for mano_io_unit at 8 clocks per serial bit.
module tb_mano_io_unit;
    logic clk = 1'b0;
    logic reset;
    logic rx;
    logic tx;
    int   checks = 0;
    int   errors = 0;

    mano_io_if bus ();

    mano_io_unit #(.CLK_DIV(8)) dut (
        .clk   (clk),
        .reset (reset),
        .rx    (rx),
        .tx    (tx),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ack_at: frame cycle whose following edge also sees inp_exec
    task automatic rx_frame(input logic [7:0] d, input logic stop,
                            input int ack_at);
        logic [9:0] f;
        f = {stop, d, 1'b0};
        for (int c = 0; c < 80; c++) begin
            rx           = f[c/8];
            bus.inp_exec = (c == ack_at);
            tick(1);
        end
        rx           = 1'b1;
        bus.inp_exec = 1'b0;
        tick(3);
    endtask

    // dup_at: frame cycle at which a stray OUT (ac_in=FF) is issued
    task automatic tx_frame(input logic [7:0] d, input int dup_at);
        logic [9:0] got;
        logic       early;
        bus.ac_in    = d;
        bus.out_exec = 1'b1;
        tick(1);
        bus.out_exec = 1'b0;
        bus.ac_in    = 8'hFF;
        chk("fgo_clr", bus.fgo, 1'b0);
        got   = '0;
        early = 1'b0;
        for (int c = 0; c < 79; c++) begin
            if (c % 8 == 4) got[c/8] = tx;
            bus.out_exec = (c == dup_at);
            tick(1);
            early |= bus.fgo;
        end
        bus.out_exec = 1'b0;
        chk("fgo_early", early, 1'b0);
        chk("tx_frame", got, {1'b1, d, 1'b0});
        tick(1);
        chk("fgo_set", bus.fgo, 1'b1);
        chk("tx_idle", tx, 1'b1);
    endtask

    task automatic pulse_ien(input logic on, input logic off,
                             input logic ack);
        bus.ion     = on;
        bus.iof     = off;
        bus.int_ack = ack;
        tick(1);
        bus.ion     = 1'b0;
        bus.iof     = 1'b0;
        bus.int_ack = 1'b0;
    endtask

    initial begin
        reset        = 1'b1;
        rx           = 1'b1;
        bus.ac_in    = '0;
        bus.inp_exec = 1'b0;
        bus.out_exec = 1'b0;
        bus.ion      = 1'b0;
        bus.iof      = 1'b0;
        bus.int_ack  = 1'b0;
        tick(3);
        reset = 1'b0;
        tick(2);
        chk("rst_tx", tx, 1'b1);
        chk("rst_fgo", bus.fgo, 1'b1);
        chk("rst_fgi", bus.fgi, 1'b0);
        chk("rst_ien", bus.ien, 1'b0);
        chk("rst_irq", bus.int_req, 1'b0);
        chk("rst_inpr", bus.inpr_out, 8'h00);
        chk("rst_ovr", bus.rx_overrun, 1'b0);

        rx_frame(8'hA5, 1'b1, -1);
        chk("a5_fgi", bus.fgi, 1'b1);
        chk("a5_inpr", bus.inpr_out, 8'hA5);
        chk("a5_ovr", bus.rx_overrun, 1'b0);
        bus.inp_exec = 1'b1;
        tick(1);
        bus.inp_exec = 1'b0;
        chk("inp_fgi", bus.fgi, 1'b0);
        chk("inp_inpr", bus.inpr_out, 8'hA5);

        tx_frame(8'h3C, -1);

        rx_frame(8'h22, 1'b0, -1);
        chk("ferr_fgi", bus.fgi, 1'b0);
        chk("ferr_inpr", bus.inpr_out, 8'hA5);

        rx_frame(8'h66, 1'b1, -1);
        chk("66_fgi", bus.fgi, 1'b1);
        chk("66_inpr", bus.inpr_out, 8'h66);
        rx_frame(8'h99, 1'b1, 78);
        chk("coinc_fgi", bus.fgi, 1'b1);
        chk("coinc_inpr", bus.inpr_out, 8'h99);
        chk("coinc_ovr", bus.rx_overrun, 1'b0);
        rx_frame(8'h11, 1'b1, -1);
        chk("ovr_set", bus.rx_overrun, 1'b1);
        chk("ovr_inpr", bus.inpr_out, 8'h99);
        chk("ovr_fgi", bus.fgi, 1'b1);

        pulse_ien(1'b1, 1'b0, 1'b0);
        chk("ion_ien", bus.ien, 1'b1);
        chk("ion_irq", bus.int_req, 1'b1);
        pulse_ien(1'b0, 1'b0, 1'b1);
        chk("ack_ien", bus.ien, 1'b0);
        chk("ack_irq", bus.int_req, 1'b0);
        pulse_ien(1'b1, 1'b0, 1'b0);
        pulse_ien(1'b0, 1'b1, 1'b0);
        chk("iof_ien", bus.ien, 1'b0);
        pulse_ien(1'b1, 1'b0, 1'b0);
        pulse_ien(1'b1, 1'b1, 1'b0);
        chk("ioniof_ien", bus.ien, 1'b0);
        pulse_ien(1'b1, 1'b0, 1'b1);
        chk("ionack_ien", bus.ien, 1'b0);

        bus.inp_exec = 1'b1;
        tick(1);
        bus.inp_exec = 1'b0;
        rx = 1'b0;
        tick(3);
        rx = 1'b1;
        tick(100);
        chk("glitch_fgi", bus.fgi, 1'b0);
        chk("ovr_sticky", bus.rx_overrun, 1'b1);

        bus.ac_in    = 8'h81;
        bus.out_exec = 1'b1;
        tick(1);
        bus.out_exec = 1'b0;
        tick(30);
        chk("mid_tx", tx, 1'b0);
        reset = 1'b1;
        #1;
        chk("arst_tx", tx, 1'b1);
        chk("arst_fgo", bus.fgo, 1'b1);
        chk("arst_inpr", bus.inpr_out, 8'h00);
        chk("arst_ovr", bus.rx_overrun, 1'b0);
        tick(1);
        reset = 1'b0;
        tick(2);
        tx_frame(8'h5A, 20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mano_io_unit.md
Name: mano_io_unit

Overview:
Serial I/O unit for the MANO computer. It implements the classic INPR/OUTR registers, the FGI/FGO flags and the IEN interrupt-enable bit.
- UART receiver fills INPR; UART transmitter serialises OUTR, which is loaded from AC[7:0].
- Sits between the accumulator and the control unit. It consumes AC on OUT and feeds INPR, flags and interrupt request back to the control unit for INP/SKI/SKO/ION/IOF execution.

Parameters:
CLK_DIV, 434, clock cycles per serial bit (50 MHz / 115200); legal range is 4 or more.
DATA_BITS, 8, serial data bits per frame (fixed 8; kept as a constant for readability).

Ports:
clk  input  1  system clock
reset  input  1  asynchronous reset, active-high
rx  input  1  serial input, idle high, asynchronous to clk
tx  output  1  serial output, idle high
ac_in  input  8  AC[7:0], loaded into OUTR on out_exec
inp_exec  input  1  one-cycle pulse: INP executing; clears FGI
out_exec  input  1  one-cycle pulse: OUT executing; loads OUTR, clears FGO
ion  input  1  one-cycle pulse: set IEN
iof  input  1  one-cycle pulse: clear IEN
int_ack  input  1  one-cycle pulse: interrupt cycle entered; clear IEN
inpr_out  output  8  INPR contents
fgi  output  1  input flag, byte available
fgo  output  1  output flag, transmitter ready
ien  output  1  interrupt enable
int_req  output  1  combinational: ien & (fgi | fgo)
rx_overrun  output  1  sticky: a byte arrived while FGI=1

Behaviour:
- Reset (async): tx=1, inpr_out=0, fgi=0, fgo=1, ien=0, rx_overrun=0. Both FSMs go to IDLE and counters clear. Reset mid-frame aborts the frame; tx=1 immediately.
- rx passes through a 2-flop synchroniser. All RX decisions use the synchronised value.
- RX FSM states: IDLE, START, DATA, STOP.
  - IDLE: synchronised rx=0 -> START, counter=CLK_DIV/2-1.
  - START: at counter expiry, rx=0 -> DATA (counter=CLK_DIV-1, bit index 0); rx=1 -> IDLE (glitch rejected).
  - DATA: at each expiry, shift in rx, LSB first. After bit 7 -> STOP.
  - STOP: after CLK_DIV, sample rx.
    - rx=1 and FGI=0: INPR<=byte, FGI<=1.
    - rx=1 and FGI=1: byte discarded, INPR unchanged, rx_overrun<=1.
    - rx=0 (framing error): byte discarded, flags unchanged.
    - In every case -> IDLE.
- inp_exec clears FGI the next edge. INPR is held; the control unit reads inpr_out combinationally in the same cycle.
- inp_exec coinciding with a byte completion: the new byte is loaded, FGI ends 1, no overrun.
- rx_overrun is cleared only by reset.
- TX FSM states: IDLE, START, DATA, STOP.
  - out_exec with FGO=1: OUTR<=ac_in, FGO<=0, -> START; tx=0 from the next edge.
  - out_exec with FGO=0 is ignored; software must SKO first.
  - Each bit is held CLK_DIV cycles: start 0, data LSB first, stop 1.
  - At the end of the stop bit, FGO<=1 -> IDLE. FGO rises exactly 10*CLK_DIV cycles after the out_exec edge.
- IEN priority: int_ack > iof > ion. Simultaneous ion and iof -> IEN=0.
- int_req is purely combinational from registered state; it changes no earlier than one edge after its cause.

Decomposition:
- Package mano_io_pkg holds: enum rx_state_t and tx_state_t (IDLE/START/DATA/STOP), the DATA_BITS constant, and a default CLK_DIV localparam.
- One sub-module, mano_uart_rx: synchroniser, RX FSM, byte_valid pulse and framing_err. The top level holds INPR, flags, IEN and the TX FSM.

Test Plan:
1. Reset asserted mid-run -> tx=1, fgo=1, fgi=0, ien=0, int_req=0, inpr_out=0x00.
2. CLK_DIV=8; drive rx frame 0xA5 at 8 clk/bit -> fgi=1 and inpr_out=0xA5 within 2 cycles of the stop-bit sample. inp_exec pulse -> fgi=0, inpr_out stays 0xA5.
3. out_exec with ac_in=0x3C -> fgo=0 next cycle. tx shows 0,0,0,1,1,1,1,0,0,1, each bit 8 cycles. fgo=1 at cycle 80.
4. Second frame 0x11 while fgi=1 -> rx_overrun=1, inpr_out stays 0xA5. Frame 0x22 with stop bit 0 after clearing FGI -> fgi stays 0.
5. ion pulse with fgo=1 -> ien=1, int_req=1. int_ack -> ien=0, int_req=0. ion+iof in the same cycle -> ien=0.
6. rx low pulse of 3 cycles (less than CLK_DIV/2) -> no fgi. Reset 30 cycles into a TX frame -> tx=1 and fgo=1 immediately; a following out_exec transmits cleanly.
